credits_carousel: RTL and testbench

CREDITS_CAROUSEL -- requirements
Module: credits_carousel

---
 rtl/credits_carousel_if.sv | 27 ++
 rtl/credits_carousel.sv | 128 ++++++++++++
 tb/tb_credits_carousel.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/credits_carousel_if.sv
// credits_carousel_if: mode-select, button and display signals of the credits carousel
// active/btn_*/entry_table flow from master to slave; led/seg_data/entry_idx/paused flow back.
interface credits_carousel_if #(
    parameter int NUM_ENTRIES = 3,
    parameter int DIGITS      = 4,
    parameter int CHAR_W      = 5
);
    logic                                 active;
    logic                                 btn_next;
    logic                                 btn_prev;
    logic                                 btn_pause;
    logic [NUM_ENTRIES*DIGITS*CHAR_W-1:0] entry_table;
    logic [15:0]                          led;
    logic [DIGITS*CHAR_W-1:0]             seg_data;
    logic [3:0]                           entry_idx;
    logic                                 paused;

    modport master (
        output active, btn_next, btn_prev, btn_pause, entry_table,
        input  led, seg_data, entry_idx, paused
    );

    modport slave (
        input  active, btn_next, btn_prev, btn_pause, entry_table,
        output led, seg_data, entry_idx, paused
    );
endinterface

// File: rtl/credits_carousel.sv
// credits_carousel: cycles through credit entries with a progress thermometer, blank gaps and pause
// clk/reset: clock and synchronous active-high reset.
// bus.active low holds OFF; bus.btn_next/prev/pause are one-cycle pulses; bus.entry_table holds the entries.
// bus.led is the progress bar, bus.seg_data the shown characters, bus.entry_idx the entry, bus.paused the pause flag.
module credits_carousel #(
    parameter int                NUM_ENTRIES = 3,
    parameter int                DIGITS      = 4,
    parameter int                CHAR_W      = 5,
    parameter int                STEP_CYCLES = 18_750_000,
    parameter int                GAP_CYCLES  = 10_000_000,
    parameter logic [CHAR_W-1:0] BLANK_CHAR  = CHAR_W'(31)
) (
    input logic               clk,
    input logic               reset,
    credits_carousel_if.slave bus
);
    typedef enum logic [1:0] {OFF, SHOW, GAP, PAUSE} state_t;
    localparam int SW   = DIGITS * CHAR_W;
    localparam int CMAX = STEP_CYCLES > GAP_CYCLES ? STEP_CYCLES : GAP_CYCLES;
    localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;
    state_t          state, nxt_state;
    logic [3:0]      idx, nxt_idx, idx_inc, idx_dec, idx_btn;
    logic [3:0]      prog, nxt_prog;
    logic [CW-1:0]   cnt, nxt_cnt;
    logic            nav, step_end, gap_end;
    logic [15:0]     led_d, led_q;
    logic            paused_d, paused_q;
    logic [SW-1:0]   seg_d, seg_q;
    logic [SW-1:0]   ents [16];
    for (genvar k = 0; k < 16; k++) begin : g_ent
        if (k < NUM_ENTRIES) begin : g_used
            assign ents[k] = bus.entry_table[k*SW +: SW];
        end else begin : g_unused
            assign ents[k] = '0;
        end
    end
    assign idx_inc  = idx == 4'(NUM_ENTRIES - 1) ? 4'd0 : idx + 4'd1;
    assign idx_dec  = idx == 4'd0 ? 4'(NUM_ENTRIES - 1) : idx - 4'd1;
    // exactly one navigation button; both together cancel out
    assign nav      = bus.btn_next ^ bus.btn_prev;
    assign idx_btn  = bus.btn_next ? idx_inc : idx_dec;
    assign step_end = cnt == CW'(STEP_CYCLES - 1);
    assign gap_end  = cnt == CW'(GAP_CYCLES - 1);
    // the step counter doubles as the gap timer; progress is always 0 in GAP
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt;
        nxt_prog  = prog;
        case (state)
            OFF: begin
                nxt_state = SHOW;
                nxt_idx   = 4'd0;
                nxt_cnt   = '0;
                nxt_prog  = 4'd0;
            end
            SHOW: begin
                if (nav) begin
                    nxt_idx   = idx_btn;
                    nxt_cnt   = '0;
                    nxt_prog  = 4'd0;
                    nxt_state = bus.btn_pause ? PAUSE : SHOW;
                end else if (bus.btn_pause) begin
                    nxt_state = PAUSE;
                end else if (!step_end) begin
                    nxt_cnt = cnt + CW'(1);
                end else begin
                    nxt_cnt  = '0;
                    nxt_prog = prog + 4'd1;
                    if (prog == 4'd15) begin
                        if (GAP_CYCLES == 0) nxt_idx = idx_inc;
                        else nxt_state = GAP;
                    end
                end
            end
            GAP: begin
                if (nav || bus.btn_pause) begin
                    nxt_idx   = nav ? idx_btn : idx_inc;
                    nxt_cnt   = '0;
                    nxt_prog  = 4'd0;
                    nxt_state = bus.btn_pause ? PAUSE : SHOW;
                end else if (gap_end) begin
                    nxt_idx   = idx_inc;
                    nxt_cnt   = '0;
                    nxt_state = SHOW;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            default: begin
                if (nav) begin
                    nxt_idx  = idx_btn;
                    nxt_cnt  = '0;
                    nxt_prog = 4'd0;
                end
                if (bus.btn_pause) nxt_state = SHOW;
            end
        endcase
    end
    // led/paused follow the new state; seg_data deliberately follows the current one
    always_comb begin
        led_d    = nxt_state == SHOW || nxt_state == PAUSE ? (16'd1 << nxt_prog) - 16'd1 : 16'd0;
        paused_d = nxt_state == PAUSE;
        seg_d    = state == GAP ? {DIGITS{BLANK_CHAR}} : ents[idx];
    end
    always_ff @(posedge clk) begin
        if (reset || !bus.active) begin
            state    <= OFF;
            idx      <= 4'd0;
            cnt      <= '0;
            prog     <= 4'd0;
            led_q    <= 16'd0;
            paused_q <= 1'b0;
        end else begin
            state    <= nxt_state;
            idx      <= nxt_idx;
            cnt      <= nxt_cnt;
            prog     <= nxt_prog;
            led_q    <= led_d;
            paused_q <= paused_d;
        end
        seg_q <= seg_d;
    end
    assign bus.led       = led_q;
    assign bus.seg_data  = seg_q;
    assign bus.entry_idx = idx;
    assign bus.paused    = paused_q;
endmodule

// File: tb/tb_credits_carousel.sv
// tb_credits_carousel: random and directed stimulus checked against a behavioural carousel model
module tb_credits_carousel;
    localparam int N = 3, D = 4, CHW = 5, S = 2, G = 3;
    localparam int SW = D * CHW, TW = N * SW, DW = 16 * S;
    localparam logic [CHW-1:0] BL = 5'd31;
    localparam logic [SW-1:0] E0 = {5'd3, 5'd11, 5'd19, 5'd3};
    localparam logic [SW-1:0] E1 = {5'd2, 5'd17, 5'd24, 5'd5};
    localparam logic [SW-1:0] E2 = {5'd1, 5'd19, 5'd24, 5'd19};
    localparam logic [SW-1:0] BLANK = {D{BL}};
    localparam int M_OFF = 0, M_SHOW = 1, M_GAP = 2, M_PAUSE = 3;

    logic clk = 0;
    logic reset = 1;
    credits_carousel_if #(.NUM_ENTRIES(N), .DIGITS(D), .CHAR_W(CHW)) bus ();
    credits_carousel #(
        .NUM_ENTRIES(N), .DIGITS(D), .CHAR_W(CHW),
        .STEP_CYCLES(S), .GAP_CYCLES(G), .BLANK_CHAR(BL)
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit chk_en = 0;
    int mmode = M_OFF, mi = 0, mt = 0, mg = 0, mv;
    bit nx, pv, pz;
    logic [15:0] e_led;
    logic [SW-1:0] e_seg;
    logic [3:0] e_idx;
    logic e_paused;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: mt counts cycles into the dwell, progress is mt/S; mg counts gap cycles
    initial forever begin
        @(posedge clk);
        nx = bus.btn_next;
        pv = bus.btn_prev;
        pz = bus.btn_pause;
        e_seg = mmode == M_GAP ? BLANK : SW'(bus.entry_table >> (mi * SW));
        mv = nx ? (mi + 1) % N : (mi + N - 1) % N;
        if (reset || !bus.active) begin
            mmode = M_OFF; mi = 0; mt = 0;
        end else if (mmode == M_OFF) begin
            mmode = M_SHOW; mi = 0; mt = 0;
        end else if (mmode == M_SHOW) begin
            if (nx != pv) begin
                mi = mv; mt = 0; mmode = pz ? M_PAUSE : M_SHOW;
            end else if (pz) begin
                mmode = M_PAUSE;
            end else begin
                mt = mt + 1;
                if (mt == DW) begin
                    mt = 0; mg = 0; mmode = M_GAP;
                end
            end
        end else if (mmode == M_GAP) begin
            if (nx != pv || pz) begin
                mi = (nx != pv) ? mv : (mi + 1) % N;
                mt = 0; mmode = pz ? M_PAUSE : M_SHOW;
            end else begin
                mg = mg + 1;
                if (mg == G) begin
                    mi = (mi + 1) % N; mt = 0; mmode = M_SHOW;
                end
            end
        end else begin
            if (nx != pv) begin
                mi = mv; mt = 0;
            end
            if (pz) mmode = M_SHOW;
        end
        e_led = (mmode == M_SHOW || mmode == M_PAUSE) ? 16'((1 << (mt / S)) - 1) : 16'h0;
        e_idx = 4'(mi);
        e_paused = mmode == M_PAUSE;
        @(negedge clk);
        if (chk_en) begin
            chk("led", bus.led, e_led);
            chk("seg_data", bus.seg_data, e_seg);
            chk("entry_idx", bus.entry_idx, e_idx);
            chk("paused", bus.paused, e_paused);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.btn_next = 0;
            bus.btn_prev = 0;
            bus.btn_pause = 0;
        end
    endtask

    task automatic press(input bit n, input bit p, input bit z);
        bus.btn_next = n;
        bus.btn_prev = p;
        bus.btn_pause = z;
        cyc(1);
    endtask

    initial begin
        bus.active = 0;
        bus.btn_next = 0;
        bus.btn_prev = 0;
        bus.btn_pause = 0;
        bus.entry_table = {E2, E1, E0};
        cyc(3);
        chk_en = 1;
        chk("rst_led", bus.led, 16'h0);
        chk("rst_idx", bus.entry_idx, 0);
        chk("rst_paused", bus.paused, 0);
        chk("rst_seg", bus.seg_data, E0);
        reset = 0;
        bus.active = 1;
        cyc(1);
        cyc(11);
        chk("led_p5", bus.led, 16'h001F);
        cyc(20);
        chk("led_p15", bus.led, 16'h7FFF);
        cyc(2);
        chk("gap_seg", bus.seg_data, BLANK);
        chk("gap_led", bus.led, 16'h0);
        cyc(2);
        chk("gap_end_idx", bus.entry_idx, 1);
        cyc(1);
        chk("show1_seg", bus.seg_data, E1);
        press(0, 1, 0);
        press(0, 1, 0);
        chk("prev_wrap_idx", bus.entry_idx, 2);
        chk("prev_led", bus.led, 16'h0);
        chk("prev_seg", bus.seg_data, E0);
        press(1, 1, 0);
        chk("both_idx", bus.entry_idx, 2);
        press(1, 0, 0);
        cyc(10);
        press(0, 0, 1);
        chk("pause_flag", bus.paused, 1);
        chk("pause_led", bus.led, 16'h001F);
        cyc(100);
        chk("pause_hold", bus.led, 16'h001F);
        press(0, 0, 1);
        chk("resume_flag", bus.paused, 0);
        cyc(2);
        chk("resume_led", bus.led, 16'h003F);
        cyc(20);
        cyc(1);
        press(0, 0, 1);
        chk("gap_pause_idx", bus.entry_idx, 1);
        chk("gap_pause_flag", bus.paused, 1);
        chk("gap_pause_led", bus.led, 16'h0);
        press(0, 0, 1);
        cyc(31);
        press(1, 0, 0);
        chk("prio_idx", bus.entry_idx, 2);
        chk("prio_led", bus.led, 16'h0);
        chk("prio_paused", bus.paused, 0);
        cyc(1);
        chk("prio_seg", bus.seg_data, E2);
        cyc(31);
        cyc(1);
        bus.active = 0;
        cyc(1);
        chk("off_idx", bus.entry_idx, 0);
        chk("off_led", bus.led, 16'h0);
        bus.active = 1;
        cyc(1);
        cyc(2);
        chk("restart_led", bus.led, 16'h0001);
        chk("restart_idx", bus.entry_idx, 0);
        repeat (4000) begin
            @(posedge clk);
            #1;
            reset = $urandom_range(0, 399) == 0;
            bus.active = $urandom_range(0, 249) != 0;
            bus.btn_next = $urandom_range(0, 39) == 0;
            bus.btn_prev = $urandom_range(0, 39) == 0;
            bus.btn_pause = $urandom_range(0, 59) == 0;
            if ($urandom_range(0, 49) == 0) bus.entry_table = TW'({$urandom(), $urandom()});
        end
        cyc(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
